data_mem_periph: RTL and testbench



---
 rtl/data_mem_periph_if.sv | 37 +++
 rtl/data_mem_periph.sv | 185 ++++++++++++++++++
 tb/tb_data_mem_periph.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_periph_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_periph_if
//  Description : MEM-stage load/store bus between the EX/MEM pipeline
//                register (master) and the data memory / peripheral block
//                (slave).
//                  mem_read   - load in MEM stage this cycle
//                  mem_write  - store in MEM stage this cycle
//                  addr       - byte address from the ALU result
//                  write_data - store data (rt value)
//                  read_data  - combinational load data toward MEM/WB
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_periph_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output mem_read,
    output mem_write,
    output addr,
    output write_data,
    input  read_data
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  addr,
    input  write_data,
    output read_data
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_periph.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_periph
//  Description : MEM-stage data RAM plus memory-mapped peripherals (timer,
//                LEDs, switches, 7-segment display) of the pipelined CPU.
//  Ports       : clk      - system clock, rising-edge active
//                reset    - asynchronous active-high reset
//                bus      - load/store bus (slave side)
//                switch   - board switches (asynchronous, synchronized here)
//                led      - LED register
//                digi     - 7-segment register {anodes[11:8], segments[7:0]}
//                irq      - timer interrupt request (level, registered only)
//  Map         : addr <  0x4000_0000  data RAM (word-indexed)
//                0x4000_0000 TH | 0x4000_0004 TL | 0x4000_0008 TCON
//                0x4000_000C LED | 0x4000_0010 SWITCH (RO) | 0x4000_0014 DIGI
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_periph #(
  parameter int RAM_DEPTH = 256,
  parameter int RAM_AW    = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  data_mem_periph_if.slave  bus,
  input  wire logic [7:0]   switch,
  output logic      [7:0]   led,
  output logic      [11:0]  digi,
  output logic              irq
);

  // Word addresses (byte address >> 2) of the peripheral registers.
  localparam logic [31:0] c_W_TH   = 32'h1000_0000;
  localparam logic [31:0] c_W_TL   = 32'h1000_0001;
  localparam logic [31:0] c_W_TCON = 32'h1000_0002;
  localparam logic [31:0] c_W_LED  = 32'h1000_0003;
  localparam logic [31:0] c_W_SW   = 32'h1000_0004;
  localparam logic [31:0] c_W_DIGI = 32'h1000_0005;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [31:0] w_word;
  logic        w_ram_region;
  logic        w_ram_hit;
  logic        w_wr_ram;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_wr_led;
  logic        w_wr_digi;

  assign w_word       = bus.addr >> 2;
  assign w_ram_region = (bus.addr < 32'h4000_0000);
  // Only the low RAM_AW word-index bits select a RAM word; anything set above
  // them (but still below the peripheral space) is an unmapped hole.
  assign w_ram_hit    = w_ram_region && (w_word[27:RAM_AW] == '0);

  assign w_wr_ram  = bus.mem_write && w_ram_hit;
  assign w_wr_th   = bus.mem_write && (w_word == c_W_TH);
  assign w_wr_tl   = bus.mem_write && (w_word == c_W_TL);
  assign w_wr_tcon = bus.mem_write && (w_word == c_W_TCON);
  assign w_wr_led  = bus.mem_write && (w_word == c_W_LED);
  assign w_wr_digi = bus.mem_write && (w_word == c_W_DIGI);

  // --------------------------------------------------------------------------
  // Data RAM (contents survive reset)
  // --------------------------------------------------------------------------
  logic [31:0] r_ram [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      r_ram[w_word[RAM_AW-1:0]] <= bus.write_data;
    end
  end

  // --------------------------------------------------------------------------
  // Timer: TH reload value, TL counter, TCON {status, int_en, tmr_en}
  // --------------------------------------------------------------------------
  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [2:0]  r_tcon;
  logic        w_tl_ovf;

  assign w_tl_ovf = (r_tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
    end else begin
      // A TH write lands together with a reload; the reload below reads the
      // pre-edge r_th, so it uses the old value.
      if (w_wr_th) begin
        r_th <= bus.write_data;
      end

      // CPU write to TL takes priority over counting/reloading.
      if (w_wr_tl) begin
        r_tl <= bus.write_data;
      end else if (r_tcon[0]) begin
        r_tl <= w_tl_ovf ? r_th : (r_tl + 32'd1);
      end

      // CPU write to TCON takes priority over the status set; this is also
      // how software acknowledges the interrupt (write bit2 = 0).
      if (w_wr_tcon) begin
        r_tcon <= bus.write_data[2:0];
      end else if (r_tcon[0] && r_tcon[1] && w_tl_ovf) begin
        r_tcon[2] <= 1'b1;
      end
    end
  end

  assign irq = r_tcon[1] & r_tcon[2];

  // --------------------------------------------------------------------------
  // LED / 7-segment registers
  // --------------------------------------------------------------------------
  logic [7:0]  r_led;
  logic [11:0] r_digi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led  <= '0;
      r_digi <= '0;
    end else begin
      if (w_wr_led) begin
        r_led <= bus.write_data[7:0];
      end
      if (w_wr_digi) begin
        r_digi <= bus.write_data[11:0];
      end
    end
  end

  assign led  = r_led;
  assign digi = r_digi;

  // --------------------------------------------------------------------------
  // Switch synchronizer (two flops, second flop is the readable value)
  // --------------------------------------------------------------------------
  logic [7:0] r_sw_meta;
  logic [7:0] r_sw_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= switch;
      r_sw_sync <= r_sw_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: purely combinational, shows pre-write state on read+write
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (bus.mem_read) begin
      if (w_ram_region) begin
        if (w_ram_hit) begin
          w_rdata = r_ram[w_word[RAM_AW-1:0]];
        end
      end else begin
        case (w_word)
          c_W_TH:   w_rdata = r_th;
          c_W_TL:   w_rdata = r_tl;
          c_W_TCON: w_rdata = {29'd0, r_tcon};
          c_W_LED:  w_rdata = {24'd0, r_led};
          c_W_SW:   w_rdata = {24'd0, r_sw_sync};
          c_W_DIGI: w_rdata = {20'd0, r_digi};
          default:  w_rdata = '0;
        endcase
      end
    end
  end

  assign bus.read_data = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_periph.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_periph
//  Description : Self-checking bench for data_mem_periph. A behavioural
//                model tracks the architectural state; a compare process
//                checks outputs against it each falling edge, and directed
//                steps pin hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_periph;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] RAM_BYTES = 32'd1024;  // 256 words

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_periph_if bus ();

  data_mem_periph #(.RAM_DEPTH(256), .RAM_AW(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  logic [31:0] m_ram [int];
  logic [31:0] m_th, m_tl, m_led, m_digi;
  bit          m_ten, m_ien, m_stat;
  logic [7:0]  m_sw_hist [2];  // [0] = sampled last edge, [1] = two edges ago

  // Returns 1 when the model knows the expected load value.
  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    logic [31:0] wa;
    wa = a & ~32'h3;
    v  = 32'd0;
    if (a < RAM_BYTES) begin
      if (!m_ram.exists(int'(a >> 2))) return 1'b0;
      v = m_ram[int'(a >> 2)];
    end else if (a >= 32'h4000_0000) begin
      if      (wa == A_TH)   v = m_th;
      else if (wa == A_TL)   v = m_tl;
      else if (wa == A_TCON) v = {29'd0, m_stat, m_ien, m_ten};
      else if (wa == A_LED)  v = m_led;
      else if (wa == A_SW)   v = {24'd0, m_sw_hist[1]};
      else if (wa == A_DIGI) v = m_digi;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [31:0] a, d, nxt_tl;
    bit          nxt_stat;
    if (reset) begin
      m_th = 0; m_tl = 0; m_led = 0; m_digi = 0;
      m_ten = 0; m_ien = 0; m_stat = 0;
      m_sw_hist[0] = 0; m_sw_hist[1] = 0;
    end else begin
      a = bus.addr & ~32'h3;
      d = bus.write_data;
      // Timer advance computed from pre-edge state.
      nxt_tl   = m_tl;
      nxt_stat = m_stat;
      if (m_ten) begin
        if (m_tl == 32'hFFFF_FFFF) begin
          nxt_tl = m_th;
          if (m_ien) nxt_stat = 1;
        end else begin
          nxt_tl = m_tl + 1;
        end
      end
      m_tl   = nxt_tl;
      m_stat = nxt_stat;
      // CPU stores override the timer's own update.
      if (bus.mem_write) begin
        if (bus.addr < RAM_BYTES) m_ram[int'(bus.addr >> 2)] = d;
        else if (a == A_TH)   m_th = d;
        else if (a == A_TL)   m_tl = d;
        else if (a == A_TCON) begin m_ten = d[0]; m_ien = d[1]; m_stat = d[2]; end
        else if (a == A_LED)  m_led = {24'd0, d[7:0]};
        else if (a == A_DIGI) m_digi = {20'd0, d[11:0]};
      end
      m_sw_hist[1] = m_sw_hist[0];
      m_sw_hist[0] = switch;
    end
  end

  // Compare process: every falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    bit          known;
    chk("led", {24'd0, led}, m_led);
    chk("digi", {20'd0, digi}, m_digi);
    chk("irq", {31'd0, irq}, {31'd0, m_ien & m_stat});
    if (bus.mem_read) begin
      known = model_read(bus.addr, exp_rd);
      if (known) chk("read_data", bus.read_data, exp_rd);
    end else begin
      chk("read_data_idle", bus.read_data, 32'd0);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drive(bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.addr       = a;
    bus.write_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    drive(0, 1, a, d);
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 32'd0, 32'd0);
    tick();
  endtask

  task automatic rd_chk(string name, logic [31:0] a, logic [31:0] exp);
    drive(1, 0, a, 32'd0);
    #1;
    chk(name, bus.read_data, exp);
    tick();
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    reset  = 1'b1;
    switch = 8'h00;
    drive(0, 0, 32'd0, 32'd0);
    #20;
    chk("reset_led", {24'd0, led}, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    #1 reset = 1'b0;
    tick();

    // RAM store/load, byte offset ignored, out-of-range behaviour.
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_load_0x13", 32'h0000_0013, 32'hDEAD_BEEF);
    rd_chk("ram_oob_0x400", 32'h0000_0400, 32'd0);
    wr(32'h0000_0000, 32'h1234_5678);
    wr(32'h0000_0400, 32'h1111_1111);          // must not alias word 0
    rd_chk("ram_no_alias", 32'h0000_0000, 32'h1234_5678);
    rd_chk("unmapped_periph", 32'h4000_0018, 32'd0);

    // Timer reload with interrupt.
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd_chk("tl_start", A_TL, 32'hFFFF_FFFE);
    rd_chk("tl_max", A_TL, 32'hFFFF_FFFF);
    chk("irq_after_ovf", {31'd0, irq}, 32'd1);
    rd_chk("tl_reloaded", A_TL, 32'hFFFF_FFFC);
    rd_chk("tcon_status", A_TCON, 32'd7);      // TL -> FFFFFFFE at this edge
    wr(A_TCON, 32'd3);                         // ack; TL -> FFFFFFFF
    chk("irq_acked", {31'd0, irq}, 32'd0);

    // Collision: TL write in the overflow cycle wins, status still sets.
    wr(A_TL, 32'h0000_0005);
    rd_chk("tl_collision", A_TL, 32'h0000_0005);
    chk("irq_collision", {31'd0, irq}, 32'd1);
    rd_chk("tcon_collision", A_TCON, 32'd7);

    // Interrupt disabled: reload happens, status stays clear.
    wr(A_TCON, 32'd1);
    wr(A_TH, 32'h0000_0100);
    wr(A_TL, 32'hFFFF_FFFE);
    idle();
    idle();
    rd_chk("tl_reload_noint", A_TL, 32'h0000_0100);
    rd_chk("tcon_noint", A_TCON, 32'd1);
    chk("irq_noint", {31'd0, irq}, 32'd0);

    // TH write in the overflow cycle: reload uses old TH.
    wr(A_TL, 32'hFFFF_FFFE);
    idle();
    wr(A_TH, 32'h0000_0200);
    rd_chk("tl_old_th", A_TL, 32'h0000_0100);
    rd_chk("th_new", A_TH, 32'h0000_0200);

    // LED / DIGI / SWITCH.
    wr(A_LED, 32'h0000_00A5);
    wr(A_DIGI, 32'h0000_03F1);
    chk("led_a5", {24'd0, led}, 32'h0000_00A5);
    chk("digi_3f1", {20'd0, digi}, 32'h0000_03F1);
    switch = 8'h5A;
    rd_chk("sw_lat0", A_SW, 32'd0);
    rd_chk("sw_lat1", A_SW, 32'd0);
    rd_chk("sw_5a", A_SW, 32'h0000_005A);
    wr(A_SW, 32'h0000_00FF);
    rd_chk("sw_write_ignored", A_SW, 32'h0000_005A);

    // Simultaneous read and write returns the pre-write value.
    drive(1, 1, A_LED, 32'h0000_003C);
    #1;
    chk("rd_during_wr", bus.read_data, 32'h0000_00A5);
    tick();
    chk("led_3c", {24'd0, led}, 32'h0000_003C);

    // Asynchronous reset mid-count with irq pending.
    wr(A_TCON, 32'd7);
    chk("irq_pre_reset", {31'd0, irq}, 32'd1);
    drive(1, 0, A_TL, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_led", {24'd0, led}, 32'd0);
    chk("async_digi", {20'd0, digi}, 32'd0);
    chk("async_irq", {31'd0, irq}, 32'd0);
    chk("async_tl", bus.read_data, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    rd_chk("ram_survives", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("tl_after_reset", A_TL, 32'd0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
